// File: rtl/sid_phase_sched.sv
// sid_phase_sched: divides the fast system clock into SID cycles.
// It emits one-cycle PHI1 / PHI2 / PHI2_PHI1 strobes and the phi2 level.
// It holds the datapath reset `res` for a fixed number of SID cycles.
// It buffers one host register write and commits it only on a PHI2 strobe.
module sid_phase_sched #(
   parameter int CLK_DIV    = 8,
   parameter int RES_CYCLES = 2
) (
   input  logic       clk,
   input  logic       res_n,
   output logic [2:0] phase,
   output logic       phi2,
   output logic       res,
   input  logic       wr_req,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       reg_we,
   output logic [4:0] reg_addr,
   output logic [7:0] reg_data
);

   localparam int CNT_W  = $clog2(CLK_DIV);
   localparam int RCNT_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_PHI1 = '0;
   localparam logic [CNT_W-1:0]  CNT_PHI2 = CNT_W'(CLK_DIV / 2);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [RCNT_W-1:0] RES_LAST = RCNT_W'(RES_CYCLES - 1);

   // Reject parameter values the phase decode cannot represent.
   generate
      if ((CLK_DIV < 4) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
         $error("sid_phase_sched: CLK_DIV must be even and >= 4");
      end
      if (RES_CYCLES < 1) begin : g_bad_res_cycles
         $error("sid_phase_sched: RES_CYCLES must be >= 1");
      end
   endgenerate

   // Phase generator state.
   logic             run;
   logic [CNT_W-1:0] cnt;

   // Reset sequencer state.
   logic [RCNT_W-1:0] res_cnt;

   // One-entry write buffer.
   logic       buf_valid;
   logic [4:0] buf_addr;
   logic [7:0] buf_data;

   // Decoded strobes and handshake decisions.
   logic phi1_hit;
   logic phi2_hit;
   logic last_hit;
   logic accept;
   logic commit;

   // Decode strobes from registered state only, so no input reaches an output combinationally.
   always_comb begin
      phi1_hit = run && (cnt == CNT_PHI1);
      phi2_hit = run && (cnt == CNT_PHI2);
      last_hit = run && (cnt == CNT_LAST);
      // The wr_ack term stops a held request from being taken twice.
      accept   = wr_req && !buf_valid && !wr_ack;
      commit   = phi2_hit && buf_valid;
   end

   assign phase = {last_hit, phi2_hit, phi1_hit};
   assign phi2  = run && (cnt >= CNT_PHI2);

   // Phase counter: run is set on the first edge after release; cnt advances only once running.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         run <= 1'b0;
         cnt <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            if (cnt == CNT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Reset sequencer: count PHI2_PHI1 strobes and drop res on the last one.
   // res therefore first reads 0 in the following PHI1 cycle.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         res     <= 1'b1;
         res_cnt <= '0;
      end else if (res && last_hit) begin
         if (res_cnt == RES_LAST) begin
            res <= 1'b0;
         end else begin
            res_cnt <= res_cnt + 1'b1;
         end
      end
   end

   // Write buffer: acknowledge accepted requests and free the entry on commit.
   // Writes accepted while res is high are acknowledged but dropped.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wr_ack    <= 1'b0;
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
      end else begin
         wr_ack <= accept;
         if (commit) begin
            buf_valid <= 1'b0;
         end else if (accept && !res) begin
            buf_valid <= 1'b1;
            buf_addr  <= wr_addr;
            buf_data  <= wr_data;
         end
      end
   end

   // Commit port: pulse reg_we on a PHI2 strobe; addr and data hold between commits.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         reg_we   <= 1'b0;
         reg_addr <= '0;
         reg_data <= '0;
      end else begin
         reg_we <= commit;
         if (commit) begin
            reg_addr <= buf_addr;
            reg_data <= buf_data;
         end
      end
   end

endmodule

// File: tb/tb_sid_phase_sched.sv
// Directed testbench for sid_phase_sched with CLK_DIV=8 and RES_CYCLES=2.
// Checks are made at the falling edge, away from the active clock edge.
module tb_sid_phase_sched;

   logic       clk;
   logic       res_n;
   logic [2:0] phase;
   logic       phi2;
   logic       res;
   logic       wr_req;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       reg_we;
   logic [4:0] reg_addr;
   logic [7:0] reg_data;

   int total = 0;
   int bad   = 0;
   int edges = 0;   // rising edges since res_n release; the first one is the run edge

   sid_phase_sched #(.CLK_DIV(8), .RES_CYCLES(2)) dut (
      .clk      (clk),
      .res_n    (res_n),
      .phase    (phase),
      .phi2     (phi2),
      .res      (res),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .reg_we   (reg_we),
      .reg_addr (reg_addr),
      .reg_data (reg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge res_n) begin
      if (!res_n) edges <= 0;
      else        edges <= edges + 1;
   end

   // Expected phase counter for the current cycle.
   function automatic int exp_cnt();
      return (edges - 1) % 8;
   endfunction

   function automatic logic [2:0] exp_phase(input int c);
      if (c == 0) return 3'b001;
      if (c == 4) return 3'b010;
      if (c == 7) return 3'b100;
      return 3'b000;
   endfunction

   // Advance by falling edges until the expected counter reads target.
   // A missed target inside the bound counts as a failure.
   task automatic wait_cnt(input int target);
      int n;
      n = 0;
      while (exp_cnt() != target && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_cnt() != target) begin
         bad++;
         $display("FAIL wait_cnt: got cnt=%0d want %0d", exp_cnt(), target);
      end
   endtask

   task automatic test_reset();
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      res_n   = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({phase, phi2, res, wr_ack, reg_we} !== 7'b0000_100) begin
         bad++;
         $display("FAIL reset_ctl: got phase=%b phi2=%b res=%b ack=%b we=%b want 000 0 1 0 0",
                  phase, phi2, res, wr_ack, reg_we);
      end
      total++;
      if ({reg_addr, reg_data} !== 13'h0) begin
         bad++;
         $display("FAIL reset_regs: got addr=%h data=%h want 00 00", reg_addr, reg_data);
      end
      res_n = 1'b1;
      @(negedge clk);
      total++;
      if (phase !== 3'b001 || phi2 !== 1'b0 || res !== 1'b1) begin
         bad++;
         $display("FAIL first_run_cycle: got phase=%b phi2=%b res=%b want 001 0 1", phase, phi2, res);
      end
   endtask

   // Write while res is high: acknowledged once, never committed.
   task automatic test_write_in_reset();
      wr_req  = 1'b1;
      wr_addr = 5'h05;
      wr_data = 8'h9A;
      @(negedge clk);
      total++;
      if (wr_ack !== 1'b1) begin
         bad++;
         $display("FAIL res_write_ack: got wr_ack=%b want 1", wr_ack);
      end
      wr_req = 1'b0;
      repeat (10) begin
         @(negedge clk);
         total++;
         if (wr_ack !== 1'b0 || reg_we !== 1'b0) begin
            bad++;
            $display("FAIL res_write_quiet: edge %0d got ack=%b we=%b want 0 0", edges, wr_ack, reg_we);
         end
      end
   endtask

   // Strobe pattern, phi2 level and res release over the reset window and beyond.
   // The write discarded in reset must never commit, so reg_we stays low throughout.
   task automatic test_phase_and_res();
      int c;
      while (edges < 34) begin
         c = exp_cnt();
         total++;
         if (phase !== exp_phase(c) || phi2 !== (c >= 4)) begin
            bad++;
            $display("FAIL phase: edge %0d cnt %0d got phase=%b phi2=%b want %b %b",
                     edges, c, phase, phi2, exp_phase(c), (c >= 4));
         end
         total++;
         if (res !== (edges < 17)) begin
            bad++;
            $display("FAIL res_seq: edge %0d got res=%b want %b", edges, res, (edges < 17));
         end
         total++;
         if (reg_we !== 1'b0) begin
            bad++;
            $display("FAIL discarded_write: edge %0d got reg_we=%b want 0", edges, reg_we);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_write();
      wait_cnt(1);
      wr_req  = 1'b1;
      wr_addr = 5'h05;
      wr_data = 8'h9A;
      @(negedge clk);   // cnt 2
      total++;
      if (wr_ack !== 1'b1 || reg_we !== 1'b0) begin
         bad++;
         $display("FAIL single_ack: got ack=%b we=%b want 1 0", wr_ack, reg_we);
      end
      wr_req = 1'b0;
      @(negedge clk);   // cnt 3
      total++;
      if (wr_ack !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_pulse: got ack=%b want 0", wr_ack);
      end
      @(negedge clk);   // cnt 4, PHI2 strobe: commit happens at the end of this cycle
      total++;
      if (reg_we !== 1'b0) begin
         bad++;
         $display("FAIL single_early: got we=%b want 0", reg_we);
      end
      @(negedge clk);   // cnt 5
      total++;
      if (reg_we !== 1'b1 || reg_addr !== 5'h05 || reg_data !== 8'h9A) begin
         bad++;
         $display("FAIL single_commit: got we=%b addr=%h data=%h want 1 05 9a", reg_we, reg_addr, reg_data);
      end
      @(negedge clk);   // cnt 6
      total++;
      if (reg_we !== 1'b0 || reg_addr !== 5'h05 || reg_data !== 8'h9A) begin
         bad++;
         $display("FAIL single_hold: got we=%b addr=%h data=%h want 0 05 9a", reg_we, reg_addr, reg_data);
      end
   endtask

   task automatic test_back_to_back();
      wait_cnt(1);
      wr_req  = 1'b1;
      wr_addr = 5'h05;
      wr_data = 8'h11;
      @(negedge clk);   // cnt 2
      total++;
      if (wr_ack !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ack1: got ack=%b want 1", wr_ack);
      end
      wr_addr = 5'h06;  // second request held straight after the first ack
      wr_data = 8'h22;
      for (int k = 3; k <= 4; k++) begin
         @(negedge clk);
         total++;
         if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL b2b_blocked: cnt %0d got ack=%b want 0", k, wr_ack);
         end
      end
      @(negedge clk);   // cnt 5: first commit; the buffer was full, so still no ack
      total++;
      if (reg_we !== 1'b1 || reg_addr !== 5'h05 || reg_data !== 8'h11 || wr_ack !== 1'b0) begin
         bad++;
         $display("FAIL b2b_commit1: got we=%b addr=%h data=%h ack=%b want 1 05 11 0",
                  reg_we, reg_addr, reg_data, wr_ack);
      end
      @(negedge clk);   // cnt 6: second request taken on the edge after the commit
      total++;
      if (wr_ack !== 1'b1 || reg_we !== 1'b0) begin
         bad++;
         $display("FAIL b2b_ack2: got ack=%b we=%b want 1 0", wr_ack, reg_we);
      end
      wr_req = 1'b0;
      wait_cnt(4);
      total++;
      if (reg_we !== 1'b0) begin
         bad++;
         $display("FAIL b2b_early: got we=%b want 0", reg_we);
      end
      @(negedge clk);   // cnt 5 of the next SID cycle
      total++;
      if (reg_we !== 1'b1 || reg_addr !== 5'h06 || reg_data !== 8'h22) begin
         bad++;
         $display("FAIL b2b_commit2: got we=%b addr=%h data=%h want 1 06 22", reg_we, reg_addr, reg_data);
      end
   endtask

   // Request raised in the PHI2 cycle with an empty buffer waits a full SID cycle.
   task automatic test_phi2_request();
      wait_cnt(4);
      wr_req  = 1'b1;
      wr_addr = 5'h1F;
      wr_data = 8'h5C;
      @(negedge clk);   // cnt 5
      total++;
      if (wr_ack !== 1'b1 || reg_we !== 1'b0) begin
         bad++;
         $display("FAIL phi2_req_ack: got ack=%b we=%b want 1 0", wr_ack, reg_we);
      end
      wr_req = 1'b0;
      repeat (7) begin
         @(negedge clk);
         total++;
         if (reg_we !== 1'b0) begin
            bad++;
            $display("FAIL phi2_req_bypass: cnt %0d got we=%b want 0", exp_cnt(), reg_we);
         end
      end
      @(negedge clk);   // cnt 5, 8 clocks after the ack cycle
      total++;
      if (reg_we !== 1'b1 || reg_addr !== 5'h1F || reg_data !== 8'h5C) begin
         bad++;
         $display("FAIL phi2_req_commit: got we=%b addr=%h data=%h want 1 1f 5c", reg_we, reg_addr, reg_data);
      end
   endtask

   // Asynchronous reset with a pending entry: outputs clear at once and the write is lost.
   task automatic test_async_reset();
      wait_cnt(1);
      wr_req  = 1'b1;
      wr_addr = 5'h0A;
      wr_data = 8'h77;
      @(negedge clk);   // cnt 2
      total++;
      if (wr_ack !== 1'b1) begin
         bad++;
         $display("FAIL async_ack: got ack=%b want 1", wr_ack);
      end
      wr_req = 1'b0;
      @(negedge clk);   // cnt 3: buffer holds the write
      #2 res_n = 1'b0;
      #1;
      total++;
      if ({phase, phi2, res, wr_ack, reg_we} !== 7'b0000_100 || {reg_addr, reg_data} !== 13'h0) begin
         bad++;
         $display("FAIL async_outputs: got phase=%b phi2=%b res=%b ack=%b we=%b addr=%h data=%h want 000 0 1 0 0 00 00",
                  phase, phi2, res, wr_ack, reg_we, reg_addr, reg_data);
      end
      @(negedge clk);
      res_n = 1'b1;
      repeat (24) begin
         @(negedge clk);
         total++;
         if (reg_we !== 1'b0) begin
            bad++;
            $display("FAIL async_lost_write: edge %0d got we=%b want 0", edges, reg_we);
         end
      end
   endtask

   initial begin
      res_n   = 1'b0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      test_reset();
      test_write_in_reset();
      test_phase_and_res();
      test_single_write();
      test_back_to_back();
      test_phi2_request();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
